// File: rtl/fifo_sync_param_if.sv
// ============================================================================
// fifo_sync_param_if : handshake and status bundle for fifo_sync_param
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_in;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_overflow;
  logic              fifo_underflow;

  // Producer/consumer side
  modport master (
    output wr, rd, data_in, clr_err,
    input  data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
  );

  // FIFO side
  modport slave (
    input  wr, rd, data_in, clr_err,
    output data_out, fifo_full, fifo_empty, fifo_almost_full,
           fifo_almost_empty, fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

`default_nettype wire

// File: rtl/fifo_sync_param.sv
// ============================================================================
// fifo_sync_param : parametrised synchronous FIFO with level flags, count,
//                   sticky error flags and selectable FWFT read mode
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_sync_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fifo_sync_param_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] c_AEMPTY_CNT = (ADDR_W+1)'(AEMPTY_LVL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              w_wr_acc, w_rd_acc;

  // A read on a full FIFO frees the slot the concurrent write lands in
  assign w_wr_acc = bus.wr & (~full_q | bus.rd);
  assign w_rd_acc = bus.rd & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (w_wr_acc && !w_rd_acc)
      count_d = count_q + 1'b1;
    else if (w_rd_acc && !w_wr_acc)
      count_d = count_q - 1'b1;
  end

  // A new error event takes priority over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.wr && full_q && !bus.rd)
      ovf_d = 1'b1;
    else if (bus.clr_err)
      ovf_d = 1'b0;
    if (bus.rd && empty_q)
      udf_d = 1'b1;
    else if (bus.clr_err)
      udf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (w_wr_acc) wptr_q <= wptr_q + 1'b1;
      if (w_rd_acc) rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
      full_q   <= (count_d == c_DEPTH_CNT);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= c_AFULL_CNT);
      aempty_q <= (count_d <= c_AEMPTY_CNT);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc)
      mem_q[wptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem_q[rptr_q];
    end else begin : g_reg_read
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (rst)
          dout_q <= '0;
        else if (w_rd_acc)
          dout_q <= mem_q[rptr_q];
      end
      assign bus.data_out = dout_q;
    end
  endgenerate

  assign bus.fifo_full         = full_q;
  assign bus.fifo_empty        = empty_q;
  assign bus.fifo_almost_full  = afull_q;
  assign bus.fifo_almost_empty = aempty_q;
  assign bus.fifo_count        = count_q;
  assign bus.fifo_overflow     = ovf_q;
  assign bus.fifo_underflow    = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
// ============================================================================
// tb_fifo_sync_param : randomized and directed checks of fifo_sync_param
//                      (registered and FWFT builds share one stimulus stream)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: a plain queue plus sticky flags and the last popped word
  logic [DW-1:0] q [$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_dout;

  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  fifo_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus1.wr      = bus0.wr;
  assign bus1.rd      = bus0.rd;
  assign bus1.data_in = bus0.data_in;
  assign bus1.clr_err = bus0.clr_err;

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(0))
    u_dut_reg (.clk(clk), .rst(rst), .bus(bus0));

  fifo_sync_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_LVL(12), .AEMPTY_LVL(2), .FWFT(1))
    u_dut_fwft (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
    bit was_full, was_empty;
    bus0.wr      = w;
    bus0.rd      = r;
    bus0.data_in = d;
    bus0.clr_err = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (r && !was_empty) m_dout = q.pop_front();
    if (w && (!was_full || r)) q.push_back(d);
    if (w && was_full && !r) m_ovf = 1'b1;
    else if (c)              m_ovf = 1'b0;
    if (r && was_empty) m_udf = 1'b1;
    else if (c)         m_udf = 1'b0;
    #1;
    bus0.wr      = 1'b0;
    bus0.rd      = 1'b0;
    bus0.clr_err = 1'b0;
  endtask

  task automatic rst_cyc(input logic w);
    rst          = 1'b1;
    bus0.wr      = w;
    bus0.rd      = 1'b0;
    bus0.clr_err = 1'b0;
    bus0.data_in = DW'($urandom);
    @(posedge clk);
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
    #1;
    rst     = 1'b0;
    bus0.wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_cyc(1'b0);
    checks++; if (bus0.fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus0.fifo_count); end
    checks++; if ({bus0.fifo_empty, bus0.fifo_almost_empty, bus0.fifo_full, bus0.fifo_almost_full} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags got %b exp 1100", {bus0.fifo_empty, bus0.fifo_almost_empty, bus0.fifo_full, bus0.fifo_almost_full}); end
    checks++; if ({bus0.fifo_overflow, bus0.fifo_underflow} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b exp 00", {bus0.fifo_overflow, bus0.fifo_underflow}); end
    checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 0", bus0.data_out); end
  endtask

  task automatic test_fill_overflow();
    rst_cyc(1'b0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, DW'(i), 1'b0);
      if (i == 11 || i == 12) begin
        checks++; if (bus0.fifo_almost_full !== (i == 12)) begin
          errors++; $display("FAIL fill_afull write %0d got %b exp %b", i, bus0.fifo_almost_full, (i == 12)); end
      end
    end
    checks++; if (bus0.fifo_full !== 1'b1 || bus0.fifo_count !== 5'd16) begin
      errors++; $display("FAIL fill_full got full=%b cnt=%0d exp full=1 cnt=16", bus0.fifo_full, bus0.fifo_count); end
    cyc(1'b1, 1'b0, 8'd17, 1'b0);
    checks++; if (bus0.fifo_overflow !== 1'b1 || bus0.fifo_count !== 5'd16) begin
      errors++; $display("FAIL overflow got ovf=%b cnt=%0d exp ovf=1 cnt=16", bus0.fifo_overflow, bus0.fifo_count); end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      checks++; if (bus0.data_out !== DW'(i)) begin
        errors++; $display("FAIL drain_data read %0d got %0h exp %0h", i, bus0.data_out, i); end
      checks++; if (bus0.fifo_almost_empty !== (16 - i <= 2)) begin
        errors++; $display("FAIL drain_aempty read %0d got %b exp %b", i, bus0.fifo_almost_empty, (16 - i <= 2)); end
    end
    checks++; if (bus0.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", bus0.fifo_empty); end
    cyc(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus0.fifo_underflow !== 1'b1 || bus0.data_out !== 8'd16) begin
      errors++; $display("FAIL underflow got udf=%b dout=%0d exp udf=1 dout=16", bus0.fifo_underflow, bus0.data_out); end
    cyc(1'b0, 1'b0, '0, 1'b1);
    checks++; if ({bus0.fifo_overflow, bus0.fifo_underflow} !== 2'b00) begin
      errors++; $display("FAIL clr_err got %b exp 00", {bus0.fifo_overflow, bus0.fifo_underflow}); end
  endtask

  task automatic test_simul_boundary();
    logic [DW-1:0] head, x;
    rst_cyc(1'b0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    head = q[0];
    cyc(1'b1, 1'b1, 8'hE7, 1'b0);
    checks++; if (bus0.fifo_count !== 5'd16 || bus0.fifo_overflow !== 1'b0 || bus0.data_out !== head) begin
      errors++; $display("FAIL full_wr_rd got cnt=%0d ovf=%b dout=%0h exp cnt=16 ovf=0 dout=%0h",
                         bus0.fifo_count, bus0.fifo_overflow, bus0.data_out, head); end
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    x = 8'h3C;
    cyc(1'b1, 1'b1, x, 1'b0);
    checks++; if (bus0.fifo_count !== 5'd1 || bus0.fifo_underflow !== 1'b1) begin
      errors++; $display("FAIL empty_wr_rd got cnt=%0d udf=%b exp cnt=1 udf=1", bus0.fifo_count, bus0.fifo_underflow); end
    cyc(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus0.data_out !== x) begin errors++; $display("FAIL empty_wr_rd_data got %0h exp %0h", bus0.data_out, x); end
  endtask

  task automatic test_wrap();
    rst_cyc(1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, DW'(8'hA0 + i), 1'b0);
    checks++; if (bus0.fifo_count !== 5'd16) begin errors++; $display("FAIL wrap_peak got %0d exp 16", bus0.fifo_count); end
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, '0, 1'b0);
      checks++; if (bus0.data_out !== DW'(8'hA0 + i)) begin
        errors++; $display("FAIL wrap_data idx %0d got %0h exp %0h", i, bus0.data_out, 8'hA0 + i); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DW'($urandom), 1'b0);
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    rst_cyc(1'b1);
    checks++; if (bus0.fifo_count !== 5'd0 || {bus0.fifo_empty, bus0.fifo_almost_empty, bus0.fifo_full,
                  bus0.fifo_almost_full, bus0.fifo_overflow, bus0.fifo_underflow} !== 6'b110000) begin
      errors++; $display("FAIL mid_reset got cnt=%0d flags=%b exp cnt=0 flags=110000", bus0.fifo_count,
                         {bus0.fifo_empty, bus0.fifo_almost_empty, bus0.fifo_full, bus0.fifo_almost_full,
                          bus0.fifo_overflow, bus0.fifo_underflow}); end
    cyc(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus0.fifo_underflow !== 1'b1) begin errors++; $display("FAIL mid_reset_udf got %b exp 1", bus0.fifo_underflow); end
  endtask

  task automatic test_fwft();
    rst_cyc(1'b0);
    cyc(1'b1, 1'b0, 8'h55, 1'b0);
    checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL fwft_head got %0h exp 55", bus1.data_out); end
    cyc(1'b1, 1'b0, 8'h66, 1'b0);
    checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL fwft_hold got %0h exp 55", bus1.data_out); end
    cyc(1'b0, 1'b1, '0, 1'b0);
    checks++; if (bus1.data_out !== 8'h66) begin errors++; $display("FAIL fwft_pop got %0h exp 66", bus1.data_out); end
    checks++; if (bus0.data_out !== 8'h55) begin errors++; $display("FAIL reg_read got %0h exp 55", bus0.data_out); end
  endtask

  task automatic test_random();
    logic w, r, c;
    int   wbias;
    logic [AW:0] exp_cnt;
    rst_cyc(1'b0);
    for (int n = 0; n < 2000; n++) begin
      wbias = ((n / 200) % 2 == 0) ? 70 : 30;
      w = ($urandom_range(99) < wbias);
      r = ($urandom_range(99) < (100 - wbias));
      c = ($urandom_range(99) < 5);
      cyc(w, r, DW'($urandom), c);
      exp_cnt = (AW+1)'(q.size());
      checks++; if (bus0.fifo_count !== exp_cnt || bus1.fifo_count !== exp_cnt) begin
        errors++; $display("FAIL rnd_count cyc %0d got %0d/%0d exp %0d", n, bus0.fifo_count, bus1.fifo_count, exp_cnt); end
      checks++; if ({bus0.fifo_full, bus0.fifo_empty, bus0.fifo_almost_full, bus0.fifo_almost_empty} !==
                    {q.size() == DEPTH, q.size() == 0, q.size() >= 12, q.size() <= 2}) begin
        errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", n,
                           {bus0.fifo_full, bus0.fifo_empty, bus0.fifo_almost_full, bus0.fifo_almost_empty},
                           {q.size() == DEPTH, q.size() == 0, q.size() >= 12, q.size() <= 2}); end
      checks++; if ({bus0.fifo_overflow, bus0.fifo_underflow} !== {m_ovf, m_udf}) begin
        errors++; $display("FAIL rnd_err cyc %0d got %b exp %b", n, {bus0.fifo_overflow, bus0.fifo_underflow}, {m_ovf, m_udf}); end
      checks++; if (bus0.data_out !== m_dout) begin
        errors++; $display("FAIL rnd_dout cyc %0d got %0h exp %0h", n, bus0.data_out, m_dout); end
      if (q.size() != 0) begin
        checks++; if (bus1.data_out !== q[0]) begin
          errors++; $display("FAIL rnd_fwft cyc %0d got %0h exp %0h", n, bus1.data_out, q[0]); end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus0.wr      = 1'b0;
    bus0.rd      = 1'b0;
    bus0.clr_err = 1'b0;
    bus0.data_in = '0;
    m_ovf        = 1'b0;
    m_udf        = 1'b0;
    m_dout       = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simul_boundary();
    test_wrap();
    test_reset_mid();
    test_fwft();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO; successor to the fixed 8-bit × 16-entry `fifo_mem`. It generalises data width and depth and adds programmable almost-full/almost-empty levels, an occupancy count and clearable sticky error flags. It also offers a selectable first-word-fall-through (FWFT) read mode. It sits between single-clock producer/consumer blocks and buffers byte/word streams.

## Interface
Parameters:
- `DATA_W`, 8, data width in bits.
- `ADDR_W`, 4, address width; `DEPTH = 2**ADDR_W` (16 by default).
- `AFULL_LVL`, 12, `fifo_almost_full` asserts when count >= this level; legal range 1..DEPTH.
- `AEMPTY_LVL`, 2, `fifo_almost_empty` asserts when count <= this level; legal range 0..DEPTH-1.
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr`  in  1  write request.
- `rd`  in  1  read request.
- `data_in`  in  DATA_W  write data.
- `clr_err`  in  1  clears the sticky overflow/underflow flags.
- `data_out`  out  DATA_W  read data.
- `fifo_full`  out  1  count == DEPTH.
- `fifo_empty`  out  1  count == 0.
- `fifo_almost_full`  out  1  count >= AFULL_LVL.
- `fifo_almost_empty`  out  1  count <= AEMPTY_LVL.
- `fifo_count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `fifo_overflow`  out  1  sticky: a write was rejected.
- `fifo_underflow`  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH × DATA_W register array, not reset. Write pointer and read pointer are each ADDR_W bits and wrap modulo DEPTH. `fifo_count` is a separate (ADDR_W+1)-bit register.
- Write accept (`wa`) = `wr & (~fifo_full | rd)`. When full, a simultaneous `rd` frees a slot, so both operations are accepted.
- Read accept (`ra`) = `rd & ~fifo_empty`. When empty, a simultaneous `wr` is accepted; the read is rejected.
- On `wa`: mem[wptr] <= `data_in`, wptr += 1.
- On `ra`: rptr += 1.
- Count update: `wa & ~ra` increments; `ra & ~wa` decrements; both or neither leaves it unchanged.
- Flags are registered and computed from the next-state count, so they are consistent with `fifo_count` in the same cycle.
- Overflow: `wr & fifo_full & ~rd` sets `fifo_overflow`.
- Underflow: `rd & fifo_empty` sets `fifo_underflow`.
- Both error flags hold until `clr_err` or `rst`. If `clr_err` and a new error event occur in the same cycle, the event wins and the flag stays 1.
- Rejected operations change no pointer, no count and no memory contents.
- FWFT=0: on `ra`, `data_out` <= mem[rptr]. Otherwise `data_out` holds its value.
- FWFT=1: `data_out` = mem[rptr], driven combinationally from the array, and valid whenever `~fifo_empty`. `rd` acknowledges (pops) the current word. When empty, `data_out` is don't-care.

## Timing
Reset values (`rst` high at a rising edge):
- wptr = rptr = 0, `fifo_count` = 0.
- `fifo_empty` = 1, `fifo_almost_empty` = 1, `fifo_full` = 0, `fifo_almost_full` = 0.
- `fifo_overflow` = 0, `fifo_underflow` = 0.
- `data_out` = 0 when FWFT=0.
- `rst` overrides `wr`, `rd` and `clr_err` in the same cycle. A reset mid-operation discards all contents.

Latency:
- Write at edge N: `fifo_count`, `fifo_empty` and the other flags reflect the write after edge N. A read is possible at edge N+1.
- FWFT=0 read: request sampled at edge N; data visible on `data_out` after edge N, i.e. one cycle of latency from asserting `rd`.
- FWFT=1: the head word is visible after the write edge that made the FIFO non-empty. Once `rd` is sampled at edge N, the next word is visible after edge N.
- Error flags assert after the edge at which the rejected request is sampled.

Sustained throughput is one write and one read per cycle, including at the full and empty boundaries as defined above.

## Test plan
- **Fill and overflow (defaults).** Reset, then write 1..16 on consecutive cycles:
  - `fifo_almost_full` asserts after the 12th write; `fifo_full` and count = 16 after the 16th.
  - A 17th write (value 17) sets `fifo_overflow`; count stays 16.
  - Draining later returns 1..16 with no 17.
- **Drain and underflow.** From full, apply 16 reads:
  - `data_out` is 1..16 in order, each one cycle after its `rd`.
  - `fifo_almost_empty` asserts at count 2; `fifo_empty` asserts after the 16th read.
  - A 17th read sets `fifo_underflow`; `data_out` holds 16.
  - Pulsing `clr_err` clears both error flags.
- **Simultaneous read/write at the boundaries.**
  - Full + `wr` + `rd`: count stays 16, no overflow, and the head word is read out.
  - Empty + `wr` + `rd`: count becomes 1, `fifo_underflow` = 1, and the written word is read on the next read.
- **Pointer wrap-around.** Write 10, read 10, then write 16 values 0xA0..0xAF and read 16: data returns in order across the pointer wrap, and count peaks at 16.
- **Reset mid-operation.** With 5 entries stored, assert `rst` together with `wr` for one cycle: count = 0, empty = 1, all flags at reset values, and the next read is rejected as underflow.
- **FWFT=1 build.** Write 0x55: `data_out` = 0x55 after the write edge with no `rd`. Write 0x66, then pulse `rd`: `data_out` = 0x66 after that edge.
